// File: rtl/lpf_pkg.sv
// Shared types and default sizes for the LPF receive path
// (window loader, integrator, TX upsampler).
package lpf_pkg;

    localparam int LPF_ARRAY_SIZE = 8;
    localparam int LPF_DATA_WIDTH = 18;
    localparam int LPF_DECIM      = 1;

    typedef logic signed [LPF_DATA_WIDTH-1:0] sample_t;
    typedef sample_t window_t [0:LPF_ARRAY_SIZE-1];

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Counter width that stays legal (>=1 bit) even for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpf_decim_counter.sv
// Modulo-DECIM event counter; o_tick marks the enabled event that wraps it.
// Shared between the RX window loader and the TX upsampler.
module lpf_decim_counter
    import lpf_pkg::*;
#(
    parameter  int DECIM = 1,
    localparam int CW    = cnt_width(DECIM)
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    logic [CW-1:0] r_count;

    assign o_tick = i_enable && (r_count == CW'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/lpf_window_loader.sv
// Streaming-to-parallel front end for lpf_integrator: keeps a sliding window of
// the last ARRAY_SIZE samples and offers it every DECIM accepts once full.
module lpf_window_loader
    import lpf_pkg::*;
#(
    parameter  int ARRAY_SIZE = LPF_ARRAY_SIZE,
    parameter  int DATA_WIDTH = LPF_DATA_WIDTH,
    parameter  int DECIM      = LPF_DECIM,
    localparam int FW         = $clog2(ARRAY_SIZE + 1)
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         flush,
    output logic signed [DATA_WIDTH-1:0] win_array [0:ARRAY_SIZE-1],
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [FW-1:0]                fill_count
);

    state_t                       r_state;
    state_t                       w_stateNext;
    logic signed [DATA_WIDTH-1:0] r_win [0:ARRAY_SIZE-1];
    logic                         r_winValid;
    logic [FW-1:0]                r_fill;

    logic w_accept;
    logic w_fillStep;
    logic w_fillDone;
    logic w_decimEn;
    logic w_decimTick;
    logic w_newWindow;

    // The window is frozen while an offered window is unconsumed; flush drops the sample.
    assign s_ready     = rst_n && (!r_winValid || win_ready);
    assign w_accept    = s_valid && s_ready && !flush;
    assign w_newWindow = w_fillDone || w_decimTick;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= FILL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            FILL:    if (w_fillDone) w_stateNext = STREAM;
            STREAM:  w_stateNext = STREAM;
            default: w_stateNext = FILL;
        endcase
    end

    always_comb begin
        w_fillStep = 1'b0;
        w_fillDone = 1'b0;
        w_decimEn  = 1'b0;
        case (r_state)
            FILL: begin
                w_fillStep = w_accept;
                w_fillDone = w_accept && (r_fill == FW'(ARRAY_SIZE - 1));
            end
            STREAM: begin
                w_decimEn = w_accept;
            end
            default: begin
                w_fillStep = 1'b0;
            end
        endcase
    end

    lpf_decim_counter #(
        .DECIM (DECIM)
    ) u_decim (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (flush || w_fillDone),
        .i_enable (w_decimEn),
        .o_tick   (w_decimTick)
    );

    // fill_count only advances in FILL, so it parks at ARRAY_SIZE while streaming.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_fill <= '0;
        end else if (w_fillStep) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < ARRAY_SIZE - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[ARRAY_SIZE-1] <= s_data;
        end
    end

    // A new window on the same edge as a consume keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_winValid <= 1'b0;
        end else if (w_newWindow) begin
            r_winValid <= 1'b1;
        end else if (r_winValid && win_ready) begin
            r_winValid <= 1'b0;
        end
    end

    assign win_array  = r_win;
    assign win_valid  = r_winValid;
    assign fill_count = r_fill;

endmodule

// File: doc/lpf_window_loader.md
Name: lpf_window_loader

Overview:
- Streaming-to-parallel front end for lpf_integrator on the receive path.
- Accepts one demodulated baseband sample per handshake and maintains a sliding window of the last ARRAY_SIZE samples.
- Presents the window as an unpacked array shaped exactly like the integrator's input_array, with a valid/ready handshake.
- Supports decimation: a new window is offered every DECIM accepted samples once the window has filled.

Parameters:
- ARRAY_SIZE, 8, window depth; must equal the lpf_integrator ARRAY_SIZE; ≥2.
- DATA_WIDTH, 18, sample width, two's complement; must equal the lpf_integrator DATA_WIDTH.
- DECIM, 1, number of accepted samples between offered windows once full; ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DATA_WIDTH  input sample.
- flush  in  1  synchronous clear of window and counters.
- win_array  out  [0:ARRAY_SIZE-1][DATA_WIDTH]  unpacked window; index 0 oldest, ARRAY_SIZE-1 newest.
- win_valid  out  1  win_array holds a complete, stable window.
- win_ready  in  1  downstream consumed the window.
- fill_count  out  $clog2(ARRAY_SIZE+1)  samples held, saturating at ARRAY_SIZE.

Behaviour:
- Reset (rst_n low at posedge):
  - win_array all zero; win_valid=0; fill_count=0; decimation counter=0; state FILL.
  - s_ready is forced 0 while rst_n is low.
- Priority: reset > flush > sample accept.
- Accept condition: s_valid && s_ready at a posedge.
  - Shift: win_array[i] <= win_array[i+1] for i<ARRAY_SIZE-1.
  - win_array[ARRAY_SIZE-1] <= s_data.
- s_ready is combinational: s_ready = rst_n && (!win_valid || win_ready).
  - The window never changes while an offered window is unconsumed.
  - Same-cycle consume-and-accept is allowed.
- States:
  - FILL: each accept increments fill_count. The accept that brings fill_count to ARRAY_SIZE sets win_valid=1 next cycle (registered; window includes that sample), clears the decimation counter, and moves to STREAM.
  - STREAM: each accept increments the decimation counter. When it reaches DECIM it wraps to 0 and win_valid is set next cycle. With DECIM=1, every accept offers a window.
- win_valid clears on posedge when win_valid && win_ready, unless the same edge accepts a sample that triggers a new window; then it stays 1 with the updated array.
- Latency: accepted sample to appearing in win_array is 1 cycle; win_valid is asserted in the same cycle the array updates.
- flush at posedge:
  - win_array zeroed, fill_count=0, counter=0, win_valid=0, state FILL.
  - Any sample presented that cycle is dropped, even if s_ready=1.
  - Any pending window is discarded without a handshake.
- Reset mid-stream: identical clearing to flush; no partial window is ever offered.
- s_data is passed through bit-exact; no arithmetic or width change. Sign handling is the integrator's job.
- fill_count stays at ARRAY_SIZE in STREAM and never wraps.

Decomposition:
- Shared package lpf_pkg:
  - sample_t (logic signed [DATA_WIDTH-1:0]).
  - window_t (sample_t array [0:ARRAY_SIZE-1]).
  - state enum {FILL, STREAM}.
  - Default LPF_ARRAY_SIZE / LPF_DATA_WIDTH constants, shared with lpf_integrator and params.svh.
- No sub-module required. The decimation counter is optionally split out as lpf_decim_counter (count, wrap, tick) for reuse by the TX upsampler.

Test Plan:
- Fill, DECIM=1: feed s_data=i<<10 for i=0..7 back-to-back with win_ready=1. win_valid first rises the cycle after the 8th accept; win_array = {0,1024,…,7168}; integrator out = 28672.
- Streaming: continue with sample 8<<10. Next cycle win_array = {1024,…,8192}, win_valid=1 every cycle, integrator out = 36864.
- Backpressure: hold win_ready=0 with s_valid=1. s_ready=0, window frozen for 5 cycles. Raise win_ready: same-cycle accept occurs and the window shifts exactly once.
- Decimation, DECIM=4: after fill, 8 further accepts produce exactly 2 win_valid assertions, after accepts 4 and 8 post-fill.
- Flush mid-fill after 5 samples: fill_count=0, win_array zeros. 8 more samples are needed before win_valid rises.
- Reset mid-stream: rst_n=0 for 1 cycle while s_valid=1. s_ready=0 during reset; all outputs zero afterwards; the sample presented during reset is not captured.
